// File: rtl/alu_pkg.sv
// Shared constants for the 8-bit ALU and its operand sequencer: datapath widths,
// function codes and the sequencer state encoding.
package alu_pkg;

  localparam int ALU_WIDTH  = 8;
  localparam int ALU_FUNC_W = 3;

  localparam logic [2:0] FUNC_ADD  = 3'b000;  // a + b + carry-in
  localparam logic [2:0] FUNC_SUB  = 3'b001;  // a - b - carry-in, carry-out = borrow
  localparam logic [2:0] FUNC_AND  = 3'b010;
  localparam logic [2:0] FUNC_OR   = 3'b011;
  localparam logic [2:0] FUNC_XOR  = 3'b100;
  localparam logic [2:0] FUNC_SHL  = 3'b101;  // carry-in shifts into bit 0
  localparam logic [2:0] FUNC_SHR  = 3'b110;  // carry-in shifts into the MSB
  localparam logic [2:0] FUNC_PASS = 3'b111;  // result = b

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GET_B = 2'd1,
    ST_EXEC  = 2'd2,
    ST_OUT   = 2'd3
  } seq_state_e;

endpackage

// File: rtl/alu_flag_reg.sv
// Stored C/Z/N flags: a capture from the ALU takes priority over a clear.
module alu_flag_reg (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic cap,
  input  logic c_d,
  input  logic z_d,
  input  logic n_d,
  output logic c_q,
  output logic z_q,
  output logic n_q
);

  // flag storage with capture-over-clear priority
  always_ff @(posedge clk) begin
    if (rst) begin
      c_q <= 1'b0;
      z_q <= 1'b0;
      n_q <= 1'b0;
    end else if (cap) begin
      c_q <= c_d;
      z_q <= z_d;
      n_q <= n_d;
    end else if (clr) begin
      c_q <= 1'b0;
      z_q <= 1'b0;
      n_q <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_operand_sequencer.sv
// Collects operand A then B from one byte stream, drives the ALU from registers and
// holds the captured result and flags for a downstream valid/ready handshake.
module alu_operand_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH  = ALU_WIDTH,
  parameter int FUNC_W = ALU_FUNC_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_data,
  input  logic [FUNC_W-1:0] in_func,
  input  logic              in_use_carry,
  input  logic              flag_clr,
  output logic [WIDTH-1:0]  alu_a,
  output logic [WIDTH-1:0]  alu_b,
  output logic              alu_cin,
  output logic [FUNC_W-1:0] alu_func,
  input  logic [WIDTH-1:0]  alu_result,
  input  logic              alu_cout,
  input  logic              alu_zero,
  input  logic              alu_neg,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_result,
  output logic              flag_c,
  output logic              flag_z,
  output logic              flag_n
);

  seq_state_e state_r;
  seq_state_e state_nxt_s;
  logic       load_a_s;
  logic       load_b_s;
  logic       capture_s;
  logic       use_carry_r;

  // next-state and load-enable decode
  always_comb begin
    state_nxt_s = state_r;
    load_a_s    = 1'b0;
    load_b_s    = 1'b0;
    capture_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (in_valid && in_ready) begin
          load_a_s    = 1'b1;
          state_nxt_s = ST_GET_B;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_GET_B: begin
        if (in_valid && in_ready) begin
          load_b_s    = 1'b1;
          state_nxt_s = ST_EXEC;
        end else begin
          state_nxt_s = ST_GET_B;
        end
      end
      ST_EXEC: begin
        capture_s   = 1'b1;
        state_nxt_s = ST_OUT;
      end
      ST_OUT: begin
        if (out_ready) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_OUT;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // operand, result and handshake registers; handshakes are decoded from next state
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_a       <= {WIDTH{1'b0}};
      alu_b       <= {WIDTH{1'b0}};
      alu_func    <= {FUNC_W{1'b0}};
      alu_cin     <= 1'b0;
      use_carry_r <= 1'b0;
      out_result  <= {WIDTH{1'b0}};
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
    end else begin
      if (load_a_s) begin
        alu_a       <= in_data;
        alu_func    <= in_func;
        use_carry_r <= in_use_carry;
      end
      // a clear landing on the B beat means the chained carry is already gone
      if (load_b_s) begin
        alu_b   <= in_data;
        alu_cin <= use_carry_r & flag_c & ~flag_clr;
      end
      if (capture_s) begin
        out_result <= alu_result;
      end
      in_ready  <= (state_nxt_s == ST_IDLE) || (state_nxt_s == ST_GET_B);
      out_valid <= (state_nxt_s == ST_OUT);
    end
  end

  alu_flag_reg u_flags (
    .clk (clk),
    .rst (rst),
    .clr (flag_clr),
    .cap (capture_s),
    .c_d (alu_cout),
    .z_d (alu_zero),
    .n_d (alu_neg),
    .c_q (flag_c),
    .z_q (flag_z),
    .n_q (flag_n)
  );

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Scoreboard bench: a behavioural ALU sits on the DUT's ALU ports, the driver pushes
// expected results from an arithmetic reference model, and a monitor checks each output.
module tb_alu_operand_sequencer;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = 8'd0;
  logic [2:0] in_func = 3'd0;
  logic       in_use_carry = 1'b0;
  logic       flag_clr = 1'b0;
  logic [7:0] alu_a, alu_b, alu_result, out_result;
  logic       alu_cin, alu_cout, alu_zero, alu_neg;
  logic [2:0] alu_func;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic       flag_c, flag_z, flag_n;
  logic [8:0] alu_sum;

  typedef struct {
    logic [7:0] a, b, res;
    logic       cin, c, z, n;
    int         bcyc;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   rdy_mode = 2;
  logic m_c = 1'b0;
  logic prev_valid = 1'b0;

  alu_operand_sequencer dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_func(in_func), .in_use_carry(in_use_carry), .flag_clr(flag_clr),
    .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin), .alu_func(alu_func),
    .alu_result(alu_result), .alu_cout(alu_cout), .alu_zero(alu_zero), .alu_neg(alu_neg),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .flag_c(flag_c), .flag_z(flag_z), .flag_n(flag_n)
  );

  always #5 clk = ~clk;

  // Behavioural ALU attached to the sequencer
  always_comb begin
    alu_sum = 9'd0;
    case (alu_func)
      FUNC_ADD: alu_sum = {1'b0, alu_a} + {1'b0, alu_b} + {8'd0, alu_cin};
      FUNC_SUB: alu_sum = {1'b0, alu_a} - {1'b0, alu_b} - {8'd0, alu_cin};
      FUNC_AND: alu_sum = {1'b0, alu_a & alu_b};
      FUNC_OR:  alu_sum = {1'b0, alu_a | alu_b};
      FUNC_XOR: alu_sum = {1'b0, alu_a ^ alu_b};
      FUNC_SHL: alu_sum = {alu_a, alu_cin};
      FUNC_SHR: alu_sum = {alu_a[0], alu_cin, alu_a[7:1]};
      default:  alu_sum = {1'b0, alu_b};
    endcase
  end
  assign {alu_cout, alu_result} = alu_sum;
  assign alu_zero = (alu_result == 8'd0);
  assign alu_neg  = alu_result[7];

  // Reference arithmetic in plain integers
  task automatic ref_alu(input logic [2:0] f, input logic [7:0] a, input logic [7:0] b,
                         input logic cin, output logic [7:0] r, output logic c);
    int s;
    s = 0;
    r = 8'd0;
    c = 1'b0;
    case (f)
      FUNC_ADD: begin s = int'(a) + int'(b) + int'(cin); r = 8'(s % 256); c = (s > 255); end
      FUNC_SUB: begin s = int'(a) - int'(b) - int'(cin); r = 8'((s + 512) % 256); c = (s < 0); end
      FUNC_AND: r = a & b;
      FUNC_OR:  r = a | b;
      FUNC_XOR: r = a ^ b;
      FUNC_SHL: begin s = 2 * int'(a) + int'(cin); r = 8'(s % 256); c = (s > 255); end
      FUNC_SHR: begin r = 8'(int'(a) / 2 + 128 * int'(cin)); c = ((int'(a) % 2) == 1); end
      default:  r = b;
    endcase
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Downstream ready: random, forced low, or forced high; changes well away from the edge
  always @(posedge clk) begin
    #2;
    case (rdy_mode)
      0: out_ready = (($urandom % 4) != 0);
      1: out_ready = 1'b0;
      default: out_ready = 1'b1;
    endcase
  end

  // Monitor: latency on each new result, full compare on each handshake
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_valid = 1'b0;
    end else begin
      if (out_valid && !prev_valid) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_out_valid: got 1 expected 0");
        end else begin
          chk("latency", cyc - q[0].bcyc, 1);
        end
      end
      if (out_valid && out_ready && q.size() != 0) begin
        e = q.pop_front();
        chk("out_result", out_result, e.res);
        chk("flag_c", flag_c, e.c);
        chk("flag_z", flag_z, e.z);
        chk("flag_n", flag_n, e.n);
        chk("alu_cin", alu_cin, e.cin);
        chk("alu_a", alu_a, e.a);
        chk("alu_b", alu_b, e.b);
      end
      prev_valid = out_valid;
    end
  end

  task automatic beat(input logic [7:0] d, input logic [2:0] f, input logic u,
                      input logic clr, output int cyc_o);
    int budget;
    budget = 60;
    in_valid = 1'b1; in_data = d; in_func = f; in_use_carry = u; flag_clr = clr;
    while (!in_ready && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (budget == 0) begin
      checks++; errors++;
      $display("FAIL beat_timeout: got in_ready 0 expected 1");
    end
    @(negedge clk);
    cyc_o = cyc;
    in_valid = 1'b0; flag_clr = 1'b0; in_data = 8'($urandom);
  endtask

  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic [2:0] f,
                       input logic u, input int gap, input logic clr_b, input logic clr_exec);
    exp_t e;
    int   t;
    beat(a, f, u, 1'b0, t);
    repeat (gap) @(negedge clk);
    e.cin = u & m_c & ~clr_b;
    beat(b, 3'($urandom), 1'($urandom), clr_b, t);
    ref_alu(f, a, b, e.cin, e.res, e.c);
    e.z = (e.res == 8'd0);
    e.n = (e.res >= 8'd128);
    e.a = a; e.b = b; e.bcyc = t;
    q.push_back(e);
    m_c = e.c;
    if (clr_exec) begin
      flag_clr = 1'b1;
      @(negedge clk);
      flag_clr = 1'b0;
    end
  endtask

  task automatic drain();
    int budget;
    budget = 300;
    while ((q.size() != 0 || out_valid) && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (budget == 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
    end
  endtask

  task automatic check_reset_state();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);
    chk("rst_alu_func", alu_func, 0);
    chk("rst_alu_cin", alu_cin, 0);
    chk("rst_out_result", out_result, 0);
    chk("rst_flags", {flag_c, flag_z, flag_n}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_reset_state();

    // basic ADD
    rdy_mode = 2;
    do_op(8'h01, 8'hFE, FUNC_ADD, 1'b0, 0, 1'b0, 1'b0);
    drain();
    chk("add_result", out_result, 8'hFF);
    chk("add_flags", {flag_c, flag_z, flag_n}, 3'b001);

    // chained carry
    do_op(8'hFF, 8'h01, FUNC_ADD, 1'b0, 0, 1'b0, 1'b0);
    drain();
    chk("chain1_flags", {flag_c, flag_z}, 2'b11);
    do_op(8'h00, 8'h00, FUNC_ADD, 1'b1, 0, 1'b0, 1'b0);
    drain();
    chk("chain2_cin", alu_cin, 1);
    chk("chain2_result", out_result, 8'h01);
    chk("chain2_flags", {flag_c, flag_z}, 2'b00);

    // flag_clr in IDLE with C set
    do_op(8'hFF, 8'h01, FUNC_ADD, 1'b0, 0, 1'b0, 1'b0);
    drain();
    flag_clr = 1'b1;
    @(negedge clk);
    flag_clr = 1'b0;
    m_c = 1'b0;
    chk("idle_clr_flags", {flag_c, flag_z, flag_n}, 3'b000);

    // flag_clr coincident with capture: capture wins
    do_op(8'hFF, 8'h02, FUNC_ADD, 1'b0, 0, 1'b0, 1'b1);
    drain();
    chk("exec_clr_flag_c", flag_c, 1);
    // flag_clr on the B beat kills a chained carry
    do_op(8'h00, 8'h00, FUNC_ADD, 1'b1, 0, 1'b1, 1'b0);
    drain();

    // backpressure with stray beats during the stall
    rdy_mode = 1;
    @(negedge clk);
    do_op(8'hC0, 8'h50, FUNC_ADD, 1'b0, 0, 1'b0, 1'b0);
    t = 20;
    while (!out_valid && t > 0) begin
      @(negedge clk);
      t--;
    end
    chk("stall_reached_out", out_valid, 1);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_data = 8'($urandom);
      @(negedge clk);
      chk("stall_out_valid", out_valid, 1);
      chk("stall_in_ready", in_ready, 0);
      chk("stall_result", out_result, 8'h10);
      chk("stall_flags", {flag_c, flag_z, flag_n}, 3'b100);
    end
    in_valid = 1'b0;
    rdy_mode = 2;
    repeat (2) @(negedge clk);
    chk("release_in_ready", in_ready, 1);
    chk("release_out_valid", out_valid, 0);
    chk("release_queue_empty", q.size(), 0);

    // gapped input and randomized traffic
    rdy_mode = 0;
    do_op(8'h37, 8'h5A, FUNC_ADD, 1'b0, 3, 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      do_op(8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)), 1'($urandom),
            int'($urandom_range(0, 3)), (($urandom % 8) == 0), (($urandom % 8) == 0));
    end
    drain();

    // reset mid-GET_B discards operand A
    rdy_mode = 2;
    do_op(8'hFF, 8'h02, FUNC_ADD, 1'b0, 0, 1'b0, 1'b0);
    drain();
    beat(8'h55, FUNC_SUB, 1'b1, 1'b0, t);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    m_c = 1'b0;
    check_reset_state();
    do_op(8'h10, 8'h20, FUNC_ADD, 1'b1, 0, 1'b0, 1'b0);
    drain();
    chk("post_reset_result", out_result, 8'h30);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
